// File: rtl/led_pwm_fader_pkg.sv
// Shared definitions for the LED PWM fader: channel state encoding and the
// PWM full-scale derivation used by the top level and the channel FSMs.
package led_pwm_fader_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } chan_state_e;

  // Full-scale brightness level for a given counter width (2^bits - 1).
  function automatic int pwmMax(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: holds the brightness level and ramps it one step per tick
// toward the requested state, or snaps straight there when fading is off.
module led_fade_channel
  import led_pwm_fader_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                tick,
  input  logic                target,
  input  logic                FADE_EN,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = {PWM_BITS{1'b1}};

  chan_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;

  // Next level and state: a tick moves the level in the direction held by the
  // current state, so a request change seen on a tick cycle steers the next tick.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (!FADE_EN) begin
      level_d = target ? LEVEL_MAX : '0;
      state_d = target ? ST_ON : ST_OFF;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (target) state_d = ST_RISE;
        end
        ST_RISE: begin
          if (tick && (level_q != LEVEL_MAX)) level_d = level_q + 1'b1;
          if (!target)                   state_d = (level_d == '0) ? ST_OFF : ST_FALL;
          else if (level_d == LEVEL_MAX) state_d = ST_ON;
        end
        ST_ON: begin
          if (!target) state_d = ST_FALL;
        end
        ST_FALL: begin
          if (tick && (level_q != '0)) level_d = level_q - 1'b1;
          if (target)             state_d = (level_d == LEVEL_MAX) ? ST_ON : ST_RISE;
          else if (level_d == '0) state_d = ST_OFF;
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
  end

  // State and level registers, cleared to dark/idle on reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_OFF;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign busy  = (state_q == ST_RISE) || (state_q == ST_FALL);

endmodule

// File: rtl/led_pwm_fader.sv
// LED PWM fader top: shared PWM counter and step prescaler, two fading
// channels (red, green), registered active-low LED compares and BUSY flag.
module led_pwm_fader
  import led_pwm_fader_pkg::*;
#(
  parameter int PWM_BITS         = 8,
  parameter int FADE_STEP_CYCLES = 23529
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic REQ_RED_N,
  input  logic REQ_GREEN_N,
  input  logic FADE_EN,
  output logic LED_RED,
  output logic LED_GREEN,
  output logic BUSY
);

  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(pwmMax(PWM_BITS) - 1);
  localparam int                  PRE_W    = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(FADE_STEP_CYCLES - 1);

  logic [PWM_BITS-1:0] pwmCnt_q, pwmCnt_d;
  logic [PRE_W-1:0]    prescale_q, prescale_d;
  logic                ledRed_q, ledRed_d;
  logic                ledGreen_q, ledGreen_d;
  logic                busy_q, busy_d;
  logic                tick;
  logic [PWM_BITS-1:0] levelRed, levelGreen;
  logic                busyRed, busyGreen;

  assign tick = (prescale_q == PRE_LAST);

  led_fade_channel #(.PWM_BITS(PWM_BITS)) u_red (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .tick    (tick),
    .target  (~REQ_RED_N),
    .FADE_EN (FADE_EN),
    .level   (levelRed),
    .busy    (busyRed)
  );

  led_fade_channel #(.PWM_BITS(PWM_BITS)) u_green (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .tick    (tick),
    .target  (~REQ_GREEN_N),
    .FADE_EN (FADE_EN),
    .level   (levelGreen),
    .busy    (busyGreen)
  );

  // Counter wrap points and the PWM compare; the counter never reaches full
  // scale, so a full-scale level stays lit for the whole period.
  always_comb begin
    pwmCnt_d   = (pwmCnt_q == PWM_LAST) ? '0 : pwmCnt_q + 1'b1;
    prescale_d = tick ? '0 : prescale_q + 1'b1;
    ledRed_d   = ~(pwmCnt_q < levelRed);
    ledGreen_d = ~(pwmCnt_q < levelGreen);
    busy_d     = busyRed | busyGreen;
  end

  // Counters and output registers; LEDs dark and BUSY low while in reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pwmCnt_q   <= '0;
      prescale_q <= '0;
      ledRed_q   <= 1'b1;
      ledGreen_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      pwmCnt_q   <= pwmCnt_d;
      prescale_q <= prescale_d;
      ledRed_q   <= ledRed_d;
      ledGreen_q <= ledGreen_d;
      busy_q     <= busy_d;
    end
  end

  assign LED_RED   = ledRed_q;
  assign LED_GREEN = ledGreen_q;
  assign BUSY      = busy_q;

endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
Downstream stage of the LED pattern generator. It takes the generator's active-low on/off requests for the red and green LEDs and drives the physical LEDs with PWM. Each transition is a linear brightness ramp, so a pattern step fades in and out instead of snapping. All logic is in the 12 MHz CLK domain.

Parameters:
PWM_BITS, 8, width of the PWM counter and of each brightness level; PWM_MAX = 2^PWM_BITS-1
FADE_STEP_CYCLES, 23529, CLK cycles per one-level ramp step; a full 0->PWM_MAX ramp takes about 0.5 s at default

Ports:
CLK  input  1  12 MHz system clock; the only clock
RST_N  input  1  asynchronous active-low reset
REQ_RED_N  input  1  red request from the pattern generator; active low, 0 = on; same clock domain
REQ_GREEN_N  input  1  green request; active low, 0 = on
FADE_EN  input  1  1 = ramp between levels; 0 = level jumps immediately
LED_RED  output  1  red LED drive; active low, 0 = lit
LED_GREEN  output  1  green LED drive; active low, 0 = lit
BUSY  output  1  1 while either channel is mid-ramp

Behaviour:
- Reset: while RST_N is low, asynchronously force the following. Release is synchronous to CLK.
  - LED_RED = LED_GREEN = 1.
  - BUSY = 0.
  - Both levels = 0, PWM counter = 0, prescaler = 0, both channel FSMs = OFF.
- PWM counter:
  - Free-running, counts 0..PWM_MAX-1 and wraps to 0; period = PWM_MAX cycles.
  - Lit condition: pwm_cnt < level. Level 0 gives 0% duty; level PWM_MAX gives 100% duty with no glitch.
- LED outputs:
  - Registered: LED_x <= ~(pwm_cnt < level_x).
  - Latency is 1 cycle from a level change to the output.
- Step tick:
  - Prescaler counts 0..FADE_STEP_CYCLES-1 and wraps.
  - A single-cycle tick fires on the terminal count.
  - One prescaler is shared by both channels and runs continuously.
- Request inputs:
  - Sampled every cycle; target_x = ~REQ_x_N.
  - No synchroniser, because the source is in the same clock domain.
- Per-channel FSM states:
  - OFF: level == 0, target off.
  - RISE: target on, level < PWM_MAX.
  - ON: level == PWM_MAX, target on.
  - FALL: target off, level > 0.
- FSM transitions:
  - OFF->RISE when target goes on.
  - RISE->ON when level reaches PWM_MAX.
  - ON->FALL when target goes off.
  - FALL->OFF when level reaches 0.
  - RISE->FALL or FALL->RISE when the target reverses mid-ramp. The ramp reverses from the current level, with no jump.
- Ramp arithmetic:
  - On a tick, RISE increments level by 1 and FALL decrements it by 1.
  - Level saturates at 0 and at PWM_MAX and never wraps.
- Simultaneous events:
  - A target change in the same cycle as a tick takes effect on the next tick; the current tick uses the old direction.
  - Both channels may step on the same tick.
- FADE_EN = 0: on the next clock, level <= target ? PWM_MAX : 0 and the FSM goes directly to ON or OFF. This overrides any ramp in progress.
- FADE_EN change mid-ramp:
  - 1->0 snaps to the target.
  - 0->1 takes effect on subsequent request changes.
- BUSY: registered OR of (state == RISE or FALL) across both channels; 1 cycle behind the state.
- Reset mid-ramp: immediate return to reset values. After release, ramping restarts from level 0 if the request is still on.

Decomposition:
- Shared include led_defs.vh holds:
  - Channel state encodings OFF=2'd0, RISE=2'd1, ON=2'd2, FALL=2'd3.
  - The PWM_MAX derivation.
- Sub-module led_fade_channel is instantiated twice (red, green).
  - Inputs: CLK, RST_N, tick, target, FADE_EN.
  - Outputs: level[PWM_BITS-1:0], busy.
  - It contains the FSM and the level register.
- The top level holds the PWM counter, the prescaler, the output compare registers and the BUSY OR.

Test Plan:
All scenarios use PWM_BITS=4 (PWM_MAX=15, period 15) and FADE_STEP_CYCLES=4 unless stated.
- Reset: hold RST_N=0 for 20 cycles with REQ_RED_N=0 -> LED_RED=LED_GREEN=1 and BUSY=0 throughout; outputs go to 1 asynchronously with no clock edge required.
- Rise: after reset, drive REQ_RED_N=0 with FADE_EN=1 -> BUSY=1 within 2 cycles; red level reaches 15 after 15 ticks (60 +/-4 cycles); then LED_RED=0 continuously and BUSY=0; LED_GREEN stays 1.
- Duty: FADE_STEP_CYCLES=1000; request red; freeze observation after exactly 5 ticks -> LED_RED is low for exactly 5 of any 15 consecutive cycles.
- Reversal: request red, release it after 6 ticks (level 6) -> level steps 6,5,...,0 on successive ticks with no jump above 6; FSM goes RISE->FALL->OFF; BUSY falls after reaching 0.
- Bypass: FADE_EN=0, REQ_GREEN_N 1->0 -> green level is 15 on the next cycle and LED_GREEN=0 from the second cycle on; BUSY never asserts. Then REQ_GREEN_N=1 -> LED_GREEN=1 two cycles later.
- Reset mid-ramp: red at level 8, pulse RST_N low for 3 cycles with REQ_RED_N held 0 -> LED_RED=1 immediately; after release, level restarts at 0 and reaches 15 after 15 more ticks.
